shift_sequencer: RTL

Control stage directly upstream of the 8-bit load/shift/ASR register on the board datapath. On a start request it issues one load cycle followed by a programmed number of shift cycles, and drives the register's load_n, shift and ASR controls itself. It captures each bit leaving the register's LSB into a parallel word. It reports completion with a one-cycle done pulse, so higher-level game logic never toggles register controls by hand.

---
 rtl/shift_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: sequences one load cycle followed by a programmed number of
// shift cycles on the downstream 8-bit load/shift/ASR register. It collects every
// bit that leaves the register LSB into a parallel word and pulses done at the end.
module shift_sequencer #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] load_value,
   input  logic [CNT_W-1:0] shift_count,
   input  logic             arith,
   input  logic             serial_in,
   output logic             load_n,
   output logic             shift,
   output logic             asr,
   output logic [WIDTH-1:0] load_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] captured,
   output logic [CNT_W-1:0] shifts_done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(WIDTH);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] target_reg, target_next;
   logic             mode_reg, mode_next;
   logic [WIDTH-1:0] load_data_reg, load_data_next;
   logic [WIDTH-1:0] captured_reg, captured_next;
   logic [CNT_W-1:0] shifts_done_reg, shifts_done_next;
   logic             load_n_reg, load_n_next;
   logic             shift_reg, shift_next;
   logic             asr_reg, asr_next;
   logic             busy_reg, busy_next;
   logic             done_reg, done_next;

   logic             accept;
   logic             in_shift;
   logic [CNT_W-1:0] shifts_inc;

   assign accept     = (state_reg == ST_IDLE) && start;
   assign in_shift   = (state_reg == ST_SHIFT);
   assign shifts_inc = shifts_done_reg + CNT_W'(1);

   // Next-state logic plus the operation parameters latched on accept.
   always_comb begin
      state_next       = state_reg;
      target_next      = target_reg;
      mode_next        = mode_reg;
      load_data_next   = load_data_reg;
      shifts_done_next = shifts_done_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next       = ST_LOAD;
               load_data_next   = load_value;
               target_next      = (shift_count > MAX_COUNT) ? MAX_COUNT : shift_count;
               mode_next        = arith;
               shifts_done_next = '0;
            end
         end
         ST_LOAD: begin
            state_next = (target_reg != '0) ? ST_SHIFT : ST_DONE;
         end
         ST_SHIFT: begin
            shifts_done_next = shifts_inc;
            if (shifts_inc == target_reg) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Register controls are decoded from the upcoming state and then registered,
   // so they come straight off flops and can never glitch.
   always_comb begin
      load_n_next = 1'b1;
      shift_next  = 1'b0;
      asr_next    = 1'b0;
      busy_next   = 1'b0;
      done_next   = 1'b0;
      case (state_next)
         ST_LOAD: begin
            load_n_next = 1'b0;
            busy_next   = 1'b1;
         end
         ST_SHIFT: begin
            shift_next = 1'b1;
            asr_next   = mode_next;
            busy_next  = 1'b1;
         end
         ST_DONE: begin
            done_next = 1'b1;
            busy_next = 1'b1;
         end
         default: begin
            load_n_next = 1'b1;
         end
      endcase
   end

   // Each captured bit is written only in the shift cycle whose index matches it.
   // That leaves every bit at or above the target at zero after the accept clear.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_capture
         assign captured_next[gi] = accept ? 1'b0 :
                                    (in_shift && (shifts_done_reg == CNT_W'(gi))) ? serial_in :
                                    captured_reg[gi];
      end
   endgenerate

   // State and output registers; reset wins over any operation in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= ST_IDLE;
         target_reg      <= '0;
         mode_reg        <= 1'b0;
         load_data_reg   <= '0;
         captured_reg    <= '0;
         shifts_done_reg <= '0;
         load_n_reg      <= 1'b1;
         shift_reg       <= 1'b0;
         asr_reg         <= 1'b0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
      end else begin
         state_reg       <= state_next;
         target_reg      <= target_next;
         mode_reg        <= mode_next;
         load_data_reg   <= load_data_next;
         captured_reg    <= captured_next;
         shifts_done_reg <= shifts_done_next;
         load_n_reg      <= load_n_next;
         shift_reg       <= shift_next;
         asr_reg         <= asr_next;
         busy_reg        <= busy_next;
         done_reg        <= done_next;
      end
   end

   assign load_n      = load_n_reg;
   assign shift       = shift_reg;
   assign asr         = asr_reg;
   assign busy        = busy_reg;
   assign done        = done_reg;
   assign load_data   = load_data_reg;
   assign captured    = captured_reg;
   assign shifts_done = shifts_done_reg;

endmodule
